// File: rtl/puf_race_ctrl_pkg.sv
// Shared definitions for the ring-oscillator race PUF controller.
// Holds the controller state encoding, the LFSR feedback mask and the
// substitute seed used when the challenge is all-zero, plus the LFSR
// step helper so every user advances the sequence identically.
package puf_race_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEED,
    ST_CLEAR,
    ST_RACE,
    ST_RECORD,
    ST_DONE
  } state_e;

  // Galois right-shift feedback mask for x^8 + x^6 + x^5 + x^4 + 1.
  localparam logic [7:0] LFSR_POLY = 8'hB8;

  // An all-zero LFSR would lock up, so a zero challenge seeds with this.
  localparam logic [7:0] ZERO_SEED = 8'hA5;

  function automatic logic [7:0] lfsr_step(input logic [7:0] s);
    return {1'b0, s[7:1]} ^ (s[0] ? LFSR_POLY : 8'h00);
  endfunction

endpackage

// File: rtl/puf_race_counter.sv
// One race lane: brings an asynchronous ring-oscillator output into the
// clk domain, detects its rising edges and counts them up to a threshold.
// Ports:
//   clk, rst      clock and asynchronous active-low reset
//   ro_i          raw ring-oscillator output (asynchronous)
//   clr_i         zero the counter
//   en_i          count detected edges while high
//   thresh_i      saturation / win threshold
//   reached_o     counter has reached the threshold
module race_counter #(
  parameter int CTR_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ro_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [CTR_W-1:0] thresh_i,
  output logic             reached_o
);

  logic             sync1_q, sync2_q, prev_q;
  logic [CTR_W-1:0] cnt_q, cnt_d;
  logic             rise;

  // prev_q trails the synchronized level by one cycle for edge detection.
  assign rise = sync2_q & ~prev_q;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && rise && (cnt_q < thresh_i)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= ro_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  // A zero threshold reads as reached straight after the clear.
  assign reached_o = (cnt_q >= thresh_i);

endmodule

// File: rtl/puf_race_ctrl.sv
// Ring-oscillator race PUF controller. For each challenge it walks an
// 8-bit LFSR through RESP_BITS rounds; each round picks two ROs, races
// their edge counts to a threshold and records the winner as one bit.
// Ports:
//   clk, rst            clock and asynchronous active-low reset
//   start, challenge,   start a challenge (IDLE only); seed and threshold
//   thresh              are latched when start is accepted
//   ro_a_in, ro_b_in    asynchronous RO outputs from the external mux
//   sel_a, sel_b        RO indices for the external mux
//   ro_en               RO enable, high only while racing
//   busy, done, tmo_err status; done is a single-cycle pulse
//   response, tie_cnt   assembled response and saturating tie count
module puf_race_ctrl
  import puf_race_ctrl_pkg::*;
#(
  parameter int CTR_W     = 16,
  parameter int RESP_BITS = 8,
  parameter int TMO_W     = 20
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [7:0]           challenge,
  input  logic [CTR_W-1:0]     thresh,
  input  logic                 ro_a_in,
  input  logic                 ro_b_in,
  output logic [2:0]           sel_a,
  output logic [2:0]           sel_b,
  output logic                 ro_en,
  output logic                 busy,
  output logic                 done,
  output logic                 tmo_err,
  output logic [RESP_BITS-1:0] response,
  output logic [3:0]           tie_cnt
);

  localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  // The counter turns all-ones on the edge that leaves this value, so a
  // timed-out race lasts 2^TMO_W-1 cycles.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e                 state_q;
  logic [CTR_W-1:0]       thresh_q;
  logic [7:0]             chal_q;
  logic [7:0]             lfsr_q;
  logic [KW-1:0]          k_q;
  logic [TMO_W-1:0]       tmo_q;
  logic [2:0]             sel_a_q, sel_b_q;
  logic                   ro_en_q, busy_q, done_q, tmo_err_q, bit_q;
  logic [RESP_BITS-1:0]   resp_q;
  logic [3:0]             tie_q;
  logic                   a_reached, b_reached, tmo_hit, race_end;
  logic                   lane_clr, lane_en;

  assign lane_clr = (state_q == ST_CLEAR);
  assign lane_en  = (state_q == ST_RACE);

  race_counter #(.CTR_W(CTR_W)) u_lane_a (
    .clk       (clk),
    .rst       (rst),
    .ro_i      (ro_a_in),
    .clr_i     (lane_clr),
    .en_i      (lane_en),
    .thresh_i  (thresh_q),
    .reached_o (a_reached)
  );

  race_counter #(.CTR_W(CTR_W)) u_lane_b (
    .clk       (clk),
    .rst       (rst),
    .ro_i      (ro_b_in),
    .clr_i     (lane_clr),
    .en_i      (lane_en),
    .thresh_i  (thresh_q),
    .reached_o (b_reached)
  );

  assign tmo_hit  = (tmo_q == TMO_LAST);
  assign race_end = a_reached | b_reached | tmo_hit;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      thresh_q  <= '0;
      chal_q    <= '0;
      lfsr_q    <= '0;
      k_q       <= '0;
      tmo_q     <= '0;
      sel_a_q   <= '0;
      sel_b_q   <= '0;
      ro_en_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      tmo_err_q <= 1'b0;
      bit_q     <= 1'b0;
      resp_q    <= '0;
      tie_q     <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            chal_q    <= challenge;
            thresh_q  <= thresh;
            resp_q    <= '0;
            tie_q     <= '0;
            tmo_err_q <= 1'b0;
            k_q       <= '0;
            busy_q    <= 1'b1;
            state_q   <= ST_SEED;
          end
        end
        ST_SEED: begin
          lfsr_q  <= (chal_q == 8'h00) ? ZERO_SEED : chal_q;
          state_q <= ST_CLEAR;
        end
        ST_CLEAR: begin
          // Never race an RO against itself.
          sel_a_q <= lfsr_q[2:0];
          sel_b_q <= (lfsr_q[5:3] == lfsr_q[2:0]) ? (lfsr_q[2:0] ^ 3'b001)
                                                  : lfsr_q[5:3];
          tmo_q   <= '0;
          ro_en_q <= 1'b1;
          state_q <= ST_RACE;
        end
        ST_RACE: begin
          tmo_q <= tmo_q + 1'b1;
          if (a_reached && b_reached) begin
            bit_q <= 1'b0;
            if (tie_q != 4'hF) tie_q <= tie_q + 4'd1;
          end else if (a_reached) begin
            bit_q <= 1'b1;
          end else if (b_reached) begin
            bit_q <= 1'b0;
          end else if (tmo_hit) begin
            bit_q     <= 1'b0;
            tmo_err_q <= 1'b1;
          end
          if (race_end) begin
            ro_en_q <= 1'b0;
            state_q <= ST_RECORD;
          end
        end
        ST_RECORD: begin
          resp_q[k_q] <= bit_q;
          lfsr_q      <= lfsr_step(lfsr_q);
          if (k_q == KW'(RESP_BITS - 1)) begin
            done_q  <= 1'b1;
            state_q <= ST_DONE;
          end else begin
            k_q     <= k_q + 1'b1;
            state_q <= ST_CLEAR;
          end
        end
        ST_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign sel_a    = sel_a_q;
  assign sel_b    = sel_b_q;
  assign ro_en    = ro_en_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign tmo_err  = tmo_err_q;
  assign response = resp_q;
  assign tie_cnt  = tie_q;

endmodule

// File: tb/tb_puf_race_ctrl.sv
// Scoreboard bench for puf_race_ctrl. The stimulus side pushes per-round
// expectations (mux selects, race length where fixed) and per-challenge
// results into queues; a monitor pops and compares as the DUT raises
// ro_en and done. Expected values come from the challenge rules: the LFSR
// sequence, and the outcome implied by the RO periods driven.
module tb_puf_race_ctrl;

  localparam int CTR_W     = 16;
  localparam int RESP_BITS = 8;
  localparam int TMO_W     = 9;
  localparam int TMO_LEN   = (1 << TMO_W) - 1;
  localparam int BUDGET    = RESP_BITS * (TMO_LEN + 16) + 64;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [7:0]           challenge;
  logic [CTR_W-1:0]     thresh;
  logic                 ro_a_in, ro_b_in;
  logic [2:0]           sel_a, sel_b;
  logic                 ro_en, busy, done, tmo_err;
  logic [RESP_BITS-1:0] response;
  logic [3:0]           tie_cnt;

  always #5 clk = ~clk;

  puf_race_ctrl #(.CTR_W(CTR_W), .RESP_BITS(RESP_BITS), .TMO_W(TMO_W)) dut (
    .clk(clk), .rst(rst), .start(start), .challenge(challenge), .thresh(thresh),
    .ro_a_in(ro_a_in), .ro_b_in(ro_b_in), .sel_a(sel_a), .sel_b(sel_b),
    .ro_en(ro_en), .busy(busy), .done(done), .tmo_err(tmo_err),
    .response(response), .tie_cnt(tie_cnt)
  );

  typedef struct { int sa; int sb; int len; } round_t;
  typedef struct { int resp; int tie; int tmo; } result_t;

  round_t  rq[$];
  result_t resq[$];
  result_t last_exp;
  int total = 0;
  int bad   = 0;
  int round_idx = 0;

  // RO stimulus: square waves of period pa / pb, or both held low.
  int pa = 4, pb = 6, cyc = 0;
  bit ro_static = 1'b0;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic flag_fail(input string name);
    total++;
    bad++;
    $display("FAIL %s actual=event required=none", name);
  endtask

  initial begin
    ro_a_in = 1'b0;
    ro_b_in = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      cyc++;
      if (ro_static) begin
        ro_a_in = 1'b0;
        ro_b_in = 1'b0;
      end else begin
        ro_a_in = ((cyc % pa) < (pa / 2));
        ro_b_in = ((cyc % pb) < (pb / 2));
      end
    end
  end

  // Reference model: LFSR walk for the selects, outcome from the periods.
  task automatic push_expect(input logic [7:0] ch, input int th, input bit st);
    logic [7:0] l;
    round_t r;
    result_t e;
    l = (ch == 8'h00) ? 8'hA5 : ch;
    for (int k = 0; k < RESP_BITS; k++) begin
      r.sa = int'(l) % 8;
      r.sb = (int'(l) / 8) % 8;
      if (r.sb == r.sa) r.sb = r.sa ^ 1;
      r.len = (th == 0) ? 1 : (st ? TMO_LEN : 0);
      rq.push_back(r);
      l = (l >> 1) ^ (l[0] ? 8'hB8 : 8'h00);
    end
    e.tmo = 0;
    e.tie = 0;
    e.resp = 0;
    if (th == 0 || (!st && pa == pb)) begin
      e.tie = (RESP_BITS < 15) ? RESP_BITS : 15;
    end else if (st) begin
      e.tmo = 1;
    end else if (pa < pb) begin
      e.resp = (1 << RESP_BITS) - 1;
    end
    last_exp = e;
    resq.push_back(e);
  endtask

  task automatic pulse_start(input logic [7:0] ch, input int th);
    challenge = ch;
    thresh    = CTR_W'(th);
    start     = 1'b1;
    @(negedge clk);
    start     = 1'b0;
  endtask

  task automatic run_challenge(input logic [7:0] ch, input int th, input int fa,
                               input int fb, input bit st, input bit dup);
    int n;
    pa = fa;
    pb = fb;
    ro_static = st;
    repeat (4) @(negedge clk);
    push_expect(ch, th, st);
    round_idx = 0;
    pulse_start(ch, th);
    chk("busy_after_start", int'(busy), 1);
    if (dup) begin
      repeat (5) @(negedge clk);
      pulse_start(~ch, 0);
    end
    n = 0;
    while (busy && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) flag_fail("challenge_timeout");
    repeat (3) @(negedge clk);
    chk("hold_response", int'(response), last_exp.resp);
    chk("hold_tie_cnt", int'(tie_cnt), last_exp.tie);
    chk("hold_tmo_err", int'(tmo_err), last_exp.tmo);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_ro_en"}, int'(ro_en), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_tmo_err"}, int'(tmo_err), 0);
    chk({tag, "_response"}, int'(response), 0);
    chk({tag, "_tie_cnt"}, int'(tie_cnt), 0);
    chk({tag, "_sel_a"}, int'(sel_a), 0);
    chk({tag, "_sel_b"}, int'(sel_b), 0);
  endtask

  // Monitor: pops a round expectation on each ro_en rise, a result on done.
  initial begin
    bit ro_prev, done_prev;
    int len;
    round_t cur;
    result_t r;
    ro_prev = 1'b0;
    done_prev = 1'b0;
    len = 0;
    cur = '{sa: 0, sb: 0, len: 0};
    forever begin
      @(negedge clk);
      if (!rst) begin
        ro_prev = 1'b0;
        done_prev = 1'b0;
        len = 0;
        cur.len = 0;
      end else begin
        if (ro_en && !ro_prev) begin
          round_idx++;
          len = 0;
          if (rq.size() == 0) begin
            flag_fail("round_unexpected");
            cur = '{sa: 0, sb: 0, len: 0};
          end else begin
            cur = rq.pop_front();
            chk("sel_a", int'(sel_a), cur.sa);
            chk("sel_b", int'(sel_b), cur.sb);
          end
        end
        if (ro_en) len++;
        if (!ro_en && ro_prev && cur.len != 0) chk("race_len", len, cur.len);
        if (done) begin
          if (done_prev) begin
            flag_fail("done_wider_than_1");
          end else if (resq.size() == 0) begin
            flag_fail("done_unexpected");
          end else begin
            r = resq.pop_front();
            chk("response", int'(response), r.resp);
            chk("tie_cnt", int'(tie_cnt), r.tie);
            chk("tmo_err", int'(tmo_err), r.tmo);
          end
        end
        ro_prev = ro_en;
        done_prev = done;
      end
    end
  end

  initial begin
    int n, kind, th, fast, slow;
    rst = 1'b0;
    start = 1'b0;
    challenge = 8'h00;
    thresh = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b1;

    run_challenge(8'h3C, 100, 4, 6, 1'b0, 1'b0);  // A faster -> all ones
    run_challenge(8'h5A, 50, 4, 4, 1'b0, 1'b0);   // identical -> all ties
    run_challenge(8'h00, 20, 6, 3, 1'b0, 1'b0);   // zero seed, B faster
    run_challenge(8'h91, 10, 4, 4, 1'b1, 1'b0);   // static ROs -> timeouts
    run_challenge(8'h27, 0, 4, 6, 1'b0, 1'b0);    // zero threshold -> ties
    run_challenge(8'hC3, 25, 3, 7, 1'b0, 1'b1);   // start while busy ignored

    // Reset in the middle of the third round's race.
    pa = 4;
    pb = 6;
    ro_static = 1'b0;
    push_expect(8'h6E, 30, 1'b0);
    round_idx = 0;
    pulse_start(8'h6E, 30);
    n = 0;
    while (round_idx < 3 && n < BUDGET) begin
      @(negedge clk);
      n++;
    end
    if (n >= BUDGET) flag_fail("round3_wait_timeout");
    repeat (3) @(negedge clk);
    #2;
    rst = 1'b0;
    rq.delete();
    resq.delete();
    #1;
    check_all_zero("midrace_reset");
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("idle_after_reset", int'(busy), 0);
    run_challenge(8'h6E, 30, 4, 6, 1'b0, 1'b0);

    for (int i = 0; i < 6; i++) begin
      kind = $urandom_range(0, 3);
      th   = $urandom_range(8, 40);
      fast = $urandom_range(2, 4);
      slow = fast + $urandom_range(2, 4);
      case (kind)
        0: run_challenge(8'($urandom), th, fast, slow, 1'b0, 1'b0);
        1: run_challenge(8'($urandom), th, slow, fast, 1'b0, 1'b0);
        2: run_challenge(8'($urandom), th, fast, fast, 1'b0, 1'b0);
        default: run_challenge(8'($urandom), 0, fast, slow, 1'b0, 1'b0);
      endcase
    end

    chk("rounds_left", rq.size(), 0);
    chk("results_left", resq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puf_race_ctrl.md
PUF_RACE_CTRL -- requirements
Module: puf_race_ctrl

Interface
REQ-001 SHALL have parameter CTR_W, default 16, meaning race-counter width.
REQ-002 SHALL have parameter RESP_BITS, default 8, meaning response bits produced per challenge.
REQ-003 SHALL have parameter TMO_W, default 20, meaning timeout-counter width; timeout occurs at 2^TMO_W-1 cycles.
REQ-004 SHALL have port clk  in  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port start  in  1  begin a challenge; sampled only in IDLE.
REQ-007 SHALL have port challenge  in  8  LFSR seed; latched on accepted start.
REQ-008 SHALL have port thresh  in  CTR_W  race threshold; latched on accepted start.
REQ-009 SHALL have port ro_a_in, ro_b_in  in  1 each  asynchronous ring-oscillator outputs from the external RO mux.
REQ-010 SHALL have port sel_a, sel_b  out  3 each  RO indices driven to the external mux.
REQ-011 SHALL have port ro_en  out  1  enables the selected ROs; high only in RACE.
REQ-012 SHALL have port busy, done, tmo_err  out  1 each  status; done is a 1-cycle pulse.
REQ-013 SHALL have port response  out  RESP_BITS  assembled response word.
REQ-014 SHALL have port tie_cnt  out  4  number of tied rounds in the last challenge, saturating at 15.

Function
REQ-015 SHALL implement FSM states IDLE, SEED, CLEAR, RACE, RECORD, DONE.
REQ-016 IDLE->SEED on start=1; latch challenge/thresh; clear response, tie_cnt, tmo_err, and round index k.
REQ-017 SEED: load 8-bit Galois LFSR (poly x^8+x^6+x^5+x^4+1) with challenge; if challenge==0, load 8'hA5; ->CLEAR.
REQ-018 CLEAR (1 cycle): set sel_a=lfsr[2:0]; sel_b=lfsr[5:3], replaced by lfsr[2:0]^3'b001 when equal; zero both race counters and the timeout counter; ->RACE.
REQ-019 Each RO input SHALL pass through a 2-flop synchronizer plus rising-edge detector; each detected edge increments its counter by 1.
REQ-020 Race counters SHALL saturate at thresh and never wrap.
REQ-021 RACE exits when either counter reaches thresh; the winner bit is 1 if A reaches first, 0 if B reaches first.
REQ-022 Simultaneous arrival (same cycle) SHALL be a tie: bit=0, tie_cnt+1.
REQ-023 thresh==0 SHALL be treated as a tie on the first RACE cycle.
REQ-024 If the timeout counter reaches all-ones in RACE: bit=0, tmo_err sets sticky until next accepted start, and the sequence continues.
REQ-025 RECORD: response[k]=bit; advance LFSR one step; k+1; ->CLEAR if k<RESP_BITS-1, else ->DONE.
REQ-026 DONE: pulse done=1 for one cycle; ->IDLE.
REQ-027 busy=1 in all states except IDLE.
REQ-028 response, tie_cnt, and tmo_err SHALL hold stable from DONE until the next accepted start.
REQ-029 start asserted while busy SHALL be ignored.
REQ-030 Round latency SHALL be 1 (CLEAR) + race cycles + 1 (RECORD), plus 2-cycle synchronizer lag.

Reset
REQ-031 rst=0 SHALL immediately force: IDLE, ro_en=0, busy=0, done=0, tmo_err=0, response=0, tie_cnt=0, sel_a=sel_b=0, all counters, synchronizers, and LFSR=0.
REQ-032 Reset mid-RACE SHALL abort without a done pulse; the block needs a new start after release.

Structure
REQ-033 A shared package SHALL hold the FSM state enum, the LFSR polynomial constant, and the zero-seed substitute 8'hA5.
REQ-034 A sub-module race_counter SHALL contain one synchronizer, edge detector, and saturating counter with clr/en/thresh/reached ports; it SHALL be instantiated twice.

Verification
REQ-035 challenge=8'h3C, thresh=100, A at clk/4 and B at clk/6 -> done after 8 rounds, response=8'hFF, tie_cnt=0.
REQ-036 A and B identical clk/4 streams, thresh=50 -> response=8'h00, tie_cnt=8.
REQ-037 challenge=0 -> first-round sel_a/sel_b match LFSR seed 8'hA5 (sel_a=5, sel_b=4).
REQ-038 Both ROs static, TMO_W=6 -> each round ends after 63 RACE cycles, tmo_err=1, response=0, done pulses once.
REQ-039 rst low in round 3 RACE -> all outputs 0 next cycle, no done; a new start completes normally.
REQ-040 start pulsed while busy -> ignored; the challenge/thresh latched at the original start are retained.
